// File: rtl/fp_normalize.sv
`default_nettype none
// ============================================================================
// Module  : fp_normalize
// Brief   : Iterative normaliser. Converts a two's-complement sample into sign,
//           exponent, significand and round bit, one left shift per clock.
// Revision: 1.0 - initial release
// ============================================================================
module fp_normalize #(
    parameter int DATA_W = 12,
    parameter int EXP_W  = 3,
    parameter int SIG_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] d_in,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              sign,
    output logic [EXP_W-1:0]  exponent,
    output logic [SIG_W-1:0]  significand,
    output logic              fifth_bit,
    output logic              out_valid,
    input  logic              out_ready
);

    localparam logic [1:0] c_IDLE = 2'b00;
    localparam logic [1:0] c_NORM = 2'b01;
    localparam logic [1:0] c_DONE = 2'b10;

    localparam logic [EXP_W-1:0]  c_CNT_MAX  = {EXP_W{1'b1}};
    localparam logic [DATA_W-1:0] c_MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [DATA_W-1:0] c_MAX_POS  = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] c_ONE      = {{(DATA_W-1){1'b0}}, 1'b1};

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic              r_sgn;
    logic [DATA_W-1:0] r_mag;
    logic [EXP_W-1:0]  r_cnt;
    logic [DATA_W-1:0] w_abs;
    logic              w_norm_done;

    // The most negative sample has no positive counterpart; clamp it.
    always_comb begin
        w_abs = d_in;
        if (d_in[DATA_W-1]) begin
            if (d_in == c_MOST_NEG) begin
                w_abs = c_MAX_POS;
            end else begin
                w_abs = ~d_in + c_ONE;
            end
        end
    end

    // Magnitude MSB is always zero after the clamp; folding it in keeps the
    // stop condition safe should that ever not hold.
    assign w_norm_done = (r_mag[DATA_W-1:DATA_W-2] != 2'b00) || (r_cnt == '0);

    assign in_ready  = (r_state == c_IDLE);
    assign out_valid = (r_state == c_DONE);

    always_comb begin
        w_state_nxt = c_IDLE;
        case (r_state)
            c_IDLE: w_state_nxt = in_valid ? c_NORM : c_IDLE;
            c_NORM: w_state_nxt = w_norm_done ? c_DONE : c_NORM;
            c_DONE: w_state_nxt = out_ready ? c_IDLE : c_DONE;
            default: w_state_nxt = c_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= c_IDLE;
            r_sgn       <= 1'b0;
            r_mag       <= '0;
            r_cnt       <= '0;
            sign        <= 1'b0;
            exponent    <= '0;
            significand <= '0;
            fifth_bit   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                c_IDLE: begin
                    if (in_valid) begin
                        r_sgn <= d_in[DATA_W-1];
                        r_mag <= w_abs;
                        r_cnt <= c_CNT_MAX;
                    end
                end
                c_NORM: begin
                    if (w_norm_done) begin
                        sign        <= r_sgn;
                        exponent    <= r_cnt;
                        significand <= r_mag[DATA_W-2 -: SIG_W];
                        fifth_bit   <= r_mag[DATA_W-2-SIG_W];
                    end else begin
                        r_mag <= {r_mag[DATA_W-2:0], 1'b0};
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fp_normalize.sv
`default_nettype none
// ============================================================================
// Module  : tb_fp_normalize
// Brief   : Self-checking bench for fp_normalize using directed vectors.
// Revision: 1.0 - initial release
// ============================================================================
module tb_fp_normalize;

    typedef struct {
        logic [11:0] d;
        logic        s;
        logic [2:0]  e;
        logic [3:0]  f;
        logic        fifth;
        int          lat;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [11:0] d_in;
    logic        in_valid;
    logic        in_ready;
    logic        sign;
    logic [2:0]  exponent;
    logic [3:0]  significand;
    logic        fifth_bit;
    logic        out_valid;
    logic        out_ready;

    int total = 0;
    int bad   = 0;

    fp_normalize #(.DATA_W(12), .EXP_W(3), .SIG_W(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .d_in       (d_in),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .sign       (sign),
        .exponent   (exponent),
        .significand(significand),
        .fifth_bit  (fifth_bit),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic check_outputs(input string tag, input vec_t v);
        check({tag, "_sign"}, int'(sign), int'(v.s));
        check({tag, "_exp"}, int'(exponent), int'(v.e));
        check({tag, "_sig"}, int'(significand), int'(v.f));
        check({tag, "_fifth"}, int'(fifth_bit), int'(v.fifth));
    endtask

    // Accept one sample and wait for its result; returns with outputs valid.
    task automatic accept_and_wait(input vec_t v);
        int lat;
        check("idle_ready", int'(in_ready), 1);
        d_in     = v.d;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        check("latency", lat, v.lat);
        check("done_in_ready", int'(in_ready), 0);
        check_outputs("vec", v);
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("release_valid", int'(out_valid), 0);
    endtask

    vec_t vecs[11];
    vec_t v_mid;
    vec_t v_zero;
    vec_t v_max;
    int   seen;

    initial begin
        vecs[0]  = '{12'h7FF, 1'b0, 3'd7, 4'hF, 1'b1, 1};
        vecs[1]  = '{12'h800, 1'b1, 3'd7, 4'hF, 1'b1, 1};
        vecs[2]  = '{12'h02C, 1'b0, 3'd2, 4'hB, 1'b0, 6};
        vecs[3]  = '{12'hFD4, 1'b1, 3'd2, 4'hB, 1'b0, 6};
        vecs[4]  = '{12'h010, 1'b0, 3'd1, 4'h8, 1'b0, 7};
        vecs[5]  = '{12'h00F, 1'b0, 3'd0, 4'hF, 1'b0, 8};
        vecs[6]  = '{12'h000, 1'b0, 3'd0, 4'h0, 1'b0, 8};
        vecs[7]  = '{12'h400, 1'b0, 3'd7, 4'h8, 1'b0, 1};
        vecs[8]  = '{12'hC00, 1'b1, 3'd7, 4'h8, 1'b0, 1};
        vecs[9]  = '{12'h001, 1'b0, 3'd0, 4'h1, 1'b0, 8};
        vecs[10] = '{12'hFFF, 1'b1, 3'd0, 4'h1, 1'b0, 8};
        v_mid  = vecs[2];
        v_max  = vecs[0];
        v_zero = '{12'h000, 1'b0, 3'd0, 4'h0, 1'b0, 0};

        rst_n     = 1'b0;
        d_in      = 12'h000;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_in_ready", int'(in_ready), 1);
        check_outputs("rst", v_zero);
        rst_n = 1'b1;

        for (int i = 0; i < 11; i++) begin
            accept_and_wait(vecs[i]);
            release_result();
        end

        // Back-pressure: result held, new requests ignored.
        accept_and_wait(v_mid);
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0];
            d_in     = 12'($urandom);
            @(posedge clk);
            @(negedge clk);
            check("bp_in_ready", int'(in_ready), 0);
            check("bp_out_valid", int'(out_valid), 1);
            check_outputs("bp", v_mid);
        end
        in_valid  = 1'b1;
        d_in      = 12'h123;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check("bp_release_valid", int'(out_valid), 0);
        check("bp_no_same_edge_accept", int'(in_ready), 1);
        check_outputs("bp_hold", v_mid);
        accept_and_wait(v_max);
        release_result();

        // Reset while normalising a small sample.
        d_in     = 12'h001;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check("midrst_in_ready", int'(in_ready), 1);
        check("midrst_out_valid", int'(out_valid), 0);
        check_outputs("midrst", v_zero);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("midrst_no_result", seen, 0);
        accept_and_wait(v_max);
        release_result();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
